// File: rtl/bus_master_port.sv
// Two-master front end for the shared slave bus.
// Each master owns one holding register. The registered pending flag
// drives that master's request line to the external arbiter. A granted
// transaction is driven onto the slave bus until s_ack or timeout. The
// result is then returned to the owner with a one-cycle done pulse.
module bus_master_port #(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15,
   parameter int CW      = 8
) (
   input  logic          clk,
   input  logic          rst,
   // master A
   input  logic          a_valid,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_ready,
   output logic          a_done,
   output logic          a_err,
   output logic [DW-1:0] a_rdata,
   // master B
   input  logic          b_valid,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_ready,
   output logic          b_done,
   output logic          b_err,
   output logic [DW-1:0] b_rdata,
   // arbiter side
   output logic          Ra,
   output logic          Rb,
   input  logic          Ga,
   input  logic          Gb,
   // slave bus
   output logic          s_sel,
   output logic          s_we,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_ack
);

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;     // 0 = master A, 1 = master B
   logic [CW-1:0] cnt_q, cnt_d;
   logic          a_pend_q, a_pend_d;
   logic          b_pend_q, b_pend_d;
   logic          a_err_q, a_err_d;
   logic          b_err_q, b_err_d;
   logic [DW-1:0] a_rdata_q, a_rdata_d;
   logic [DW-1:0] b_rdata_q, b_rdata_d;

   // Holding registers carry data only, so they are not reset.
   logic          a_we_q, b_we_q;
   logic [AW-1:0] a_addr_q, b_addr_q;
   logic [DW-1:0] a_wdata_q, b_wdata_q;

   logic          a_cap, b_cap;
   logic          own_we;
   logic [AW-1:0] own_addr;
   logic [DW-1:0] own_wdata;
   logic          res_commit;
   logic          res_err;
   logic [DW-1:0] res_rdata;

   assign a_cap = a_valid && !a_pend_q;
   assign b_cap = b_valid && !b_pend_q;

   assign own_we    = owner_q ? b_we_q    : a_we_q;
   assign own_addr  = owner_q ? b_addr_q  : a_addr_q;
   assign own_wdata = owner_q ? b_wdata_q : a_wdata_q;

   assign a_ready = !a_pend_q;
   assign b_ready = !b_pend_q;
   assign Ra      = a_pend_q;
   assign Rb      = b_pend_q;

   // The bus is gated by s_sel, so it reads as zero outside ISSUE and
   // collapses the same instant an asynchronous reset hits.
   assign s_sel   = (state_q == ISSUE);
   assign s_we    = s_sel && own_we;
   assign s_addr  = s_sel ? own_addr  : '0;
   assign s_wdata = s_sel ? own_wdata : '0;

   assign a_done  = (state_q == DONE) && !owner_q;
   assign b_done  = (state_q == DONE) &&  owner_q;
   assign a_err   = a_err_q;
   assign b_err   = b_err_q;
   assign a_rdata = a_rdata_q;
   assign b_rdata = b_rdata_q;

   // Next-state: capture, arbitration response, issue timing, completion.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      a_pend_d   = a_pend_q;
      b_pend_d   = b_pend_q;
      a_err_d    = a_err_q;
      b_err_d    = b_err_q;
      a_rdata_d  = a_rdata_q;
      b_rdata_d  = b_rdata_q;
      res_commit = 1'b0;
      res_err    = 1'b0;
      res_rdata  = '0;

      if (a_cap) a_pend_d = 1'b1;
      if (b_cap) b_pend_d = 1'b1;

      unique case (state_q)
         IDLE: begin
            // A has priority when both grants arrive together; a grant
            // for a master with nothing pending is simply ignored.
            if (Ga && a_pend_q) begin
               owner_d = 1'b0;
               cnt_d   = '0;
               state_d = ISSUE;
            end else if (Gb && b_pend_q) begin
               owner_d = 1'b1;
               cnt_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Grants are not looked at here, so there is no preemption.
            if (s_ack) begin
               res_commit = 1'b1;
               res_err    = 1'b0;
               res_rdata  = own_we ? '0 : s_rdata;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               res_commit = 1'b1;
               res_err    = 1'b1;
               res_rdata  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (res_commit) begin
               state_d = DONE;
               if (owner_q) begin
                  b_err_d   = res_err;
                  b_rdata_d = res_rdata;
               end else begin
                  a_err_d   = res_err;
                  a_rdata_d = res_rdata;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (owner_q) b_pend_d = 1'b0;
            else         a_pend_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state and returned results, cleared by asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         cnt_q     <= '0;
         a_pend_q  <= 1'b0;
         b_pend_q  <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         cnt_q     <= cnt_d;
         a_pend_q  <= a_pend_d;
         b_pend_q  <= b_pend_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   // Holding registers load on acceptance and stay stable while pending.
   always_ff @(posedge clk) begin
      if (a_cap) begin
         a_we_q    <= a_we;
         a_addr_q  <= a_addr;
         a_wdata_q <= a_wdata;
      end
      if (b_cap) begin
         b_we_q    <= b_we;
         b_addr_q  <= b_addr;
         b_wdata_q <= b_wdata;
      end
   end

endmodule

// File: tb/tb_bus_master_port.sv
// Testbench for bus_master_port: plays both masters, the arbiter and the
// slave. Expected results come from a transaction-level model and are
// queued; independent monitors compare them when the DUT presents them.
module tb_bus_master_port;
   localparam int AW = 8, DW = 8, TIMEOUT = 15, CW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a_valid = 0, a_we = 0, b_valid = 0, b_we = 0, Ga = 0, Gb = 0;
   logic [7:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
   logic a_ready, a_done, a_err, b_ready, b_done, b_err, Ra, Rb, s_sel, s_we;
   logic [7:0] a_rdata, b_rdata, s_addr, s_wdata;
   logic [7:0] s_rdata = 0;
   logic s_ack = 0;

   always #5 clk = ~clk;

   bus_master_port #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .CW(CW)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
      .Ra(Ra), .Rb(Rb), .Ga(Ga), .Gb(Gb),
      .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_rdata(s_rdata), .s_ack(s_ack));

   // delay = ISSUE cycle (0-based) in which the slave acks; >= TIMEOUT: never
   typedef struct {logic we; logic [7:0] addr; logic [7:0] wdata; int delay; logic [7:0] rd;} plan_t;
   typedef struct {logic err; logic [7:0] rdata;} res_t;

   plan_t bus_q[$];
   plan_t slv_q[$];
   res_t  exp_a[$];
   res_t  exp_b[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: outcome and bus occupancy of one transaction.
   function automatic res_t model(input plan_t p);
      res_t r;
      r.err   = (p.delay >= TIMEOUT);
      r.rdata = (r.err || p.we) ? 8'h00 : p.rd;
      return r;
   endfunction

   function automatic int bus_len(input plan_t p);
      return (p.delay >= TIMEOUT) ? TIMEOUT : p.delay + 1;
   endfunction

   function automatic plan_t rand_plan();
      plan_t p;
      p.we    = 1'($urandom_range(0, 1));
      p.addr  = 8'($urandom);
      p.wdata = 8'($urandom);
      p.rd    = 8'($urandom);
      case ($urandom_range(0, 7))
         0: p.delay = TIMEOUT + $urandom_range(0, 3);
         1: p.delay = TIMEOUT - 1;
         2: p.delay = 0;
         default: p.delay = $urandom_range(0, TIMEOUT - 1);
      endcase
      return p;
   endfunction

   // Slave: acks per plan while selected, random stray acks otherwise.
   initial begin : slave
      int cnt;
      bit have;
      plan_t cur;
      cnt = 0; have = 0;
      forever begin
         @(negedge clk);
         s_ack   = 1'b0;
         s_rdata = 8'($urandom);
         if (!rst) begin
            cnt = 0; have = 0;
         end else if (s_sel) begin
            if (cnt == 0) begin
               have = (slv_q.size() > 0);
               if (have) cur = slv_q.pop_front();
            end
            if (have && cnt == cur.delay) begin
               s_ack   = 1'b1;
               s_rdata = cur.rd;
            end
            cnt++;
         end else begin
            cnt = 0; have = 0;
            if ($urandom_range(0, 3) == 0) s_ack = 1'b1;
         end
      end
   end

   // Bus monitor: content at start, stability and length of each select.
   initial begin : busmon
      bit prev, have;
      int len;
      plan_t cur;
      logic [16:0] snap;
      prev = 0; have = 0; len = 0; snap = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev = 0; have = 0; len = 0;
         end else begin
            if (s_sel && !prev) begin
               len  = 1;
               snap = {s_we, s_addr, s_wdata};
               have = (bus_q.size() > 0);
               if (!have) check("unexpected_s_sel", 1, 0);
               else begin
                  cur = bus_q.pop_front();
                  check("s_we", s_we, cur.we);
                  check("s_addr", s_addr, cur.addr);
                  check("s_wdata", s_wdata, cur.wdata);
               end
            end else if (s_sel) begin
               len++;
               check("s_bus_stable", {s_we, s_addr, s_wdata}, snap);
            end else if (prev && have) begin
               check("s_sel_length", len, bus_len(cur));
            end
            prev = s_sel;
         end
      end
   end

   // Master A result monitor.
   initial begin : mon_a
      bit chk_next;
      res_t last, r;
      chk_next = 0; last = '{1'b0, 8'h00};
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk_next = 0; last = '{1'b0, 8'h00};
            check("a_done_in_reset", a_done, 0);
         end else begin
            if (chk_next) begin
               check("a_ready_after_done", a_ready, 1);
               check("Ra_after_done", Ra, 0);
               chk_next = 0;
            end
            if (a_done) begin
               if (exp_a.size() == 0) check("a_done_unexpected", 1, 0);
               else begin
                  r = exp_a.pop_front();
                  check("a_err", a_err, r.err);
                  check("a_rdata", a_rdata, r.rdata);
                  last = r;
               end
               chk_next = 1;
            end else begin
               check("a_result_held", {a_err, a_rdata}, {last.err, last.rdata});
            end
         end
      end
   end

   // Master B result monitor.
   initial begin : mon_b
      bit chk_next;
      res_t last, r;
      chk_next = 0; last = '{1'b0, 8'h00};
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk_next = 0; last = '{1'b0, 8'h00};
            check("b_done_in_reset", b_done, 0);
         end else begin
            if (chk_next) begin
               check("b_ready_after_done", b_ready, 1);
               check("Rb_after_done", Rb, 0);
               chk_next = 0;
            end
            if (b_done) begin
               if (exp_b.size() == 0) check("b_done_unexpected", 1, 0);
               else begin
                  r = exp_b.pop_front();
                  check("b_err", b_err, r.err);
                  check("b_rdata", b_rdata, r.rdata);
                  last = r;
               end
               chk_next = 1;
            end else begin
               check("b_result_held", {b_err, b_rdata}, {last.err, last.rdata});
            end
         end
      end
   end

   task automatic drive_offer(input bit m, input plan_t p);
      if (!m) begin a_valid = 1; a_we = p.we; a_addr = p.addr; a_wdata = p.wdata; end
      else    begin b_valid = 1; b_we = p.we; b_addr = p.addr; b_wdata = p.wdata; end
   endtask

   // Drop offers after the accepting edge and scramble the fields.
   task automatic end_offer();
      @(posedge clk);
      #1;
      a_valid = 0; b_valid = 0;
      a_we = 1'($urandom); a_addr = 8'($urandom); a_wdata = 8'($urandom);
      b_we = 1'($urandom); b_addr = 8'($urandom); b_wdata = 8'($urandom);
   endtask

   task automatic pulse_grant(input bit ga, input bit gb, input int extra);
      Ga = ga; Gb = gb;
      @(posedge clk);
      repeat (extra) @(posedge clk);
      #1;
      Ga = 0; Gb = 0;
   endtask

   task automatic wait_ready(input bit m);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((m ? b_ready : a_ready) === 1'b1) begin ok = 1; break; end
      end
      check("wait_ready_timeout", ok, 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (a_ready && b_ready && !s_sel) begin ok = 1; break; end
      end
      check("wait_idle_timeout", ok, 1);
   endtask

   task automatic run_single(input bit m, input plan_t p, input bit stray);
      bus_q.push_back(p);
      slv_q.push_back(p);
      if (!m) exp_a.push_back(model(p)); else exp_b.push_back(model(p));
      drive_offer(m, p);
      end_offer();
      @(negedge clk);
      check(m ? "Rb_after_accept" : "Ra_after_accept", m ? Rb : Ra, 1);
      check(m ? "b_ready_pending" : "a_ready_pending", m ? b_ready : a_ready, 0);
      if (stray) begin
         pulse_grant(m, !m, 0);
         @(negedge clk);
         check("stray_grant_ignored", s_sel, 0);
      end
      pulse_grant(!m, m, $urandom_range(0, 1));
      wait_idle();
   endtask

   // Both pending; bfirst selects whether B is granted alone first.
   task automatic run_pair(input plan_t pa, input plan_t pb, input bit bfirst);
      if (bfirst) begin bus_q.push_back(pb); slv_q.push_back(pb); bus_q.push_back(pa); slv_q.push_back(pa); end
      else        begin bus_q.push_back(pa); slv_q.push_back(pa); bus_q.push_back(pb); slv_q.push_back(pb); end
      exp_a.push_back(model(pa));
      exp_b.push_back(model(pb));
      drive_offer(0, pa);
      drive_offer(1, pb);
      end_offer();
      @(negedge clk);
      check("Ra_Rb_both", {Ra, Rb}, 2'b11);
      pulse_grant(!bfirst, 1'b1, 0);
      wait_ready(bfirst);
      check("second_still_pending", bfirst ? Ra : Rb, 1);
      pulse_grant(bfirst, !bfirst, 0);
      wait_idle();
   endtask

   initial begin : stim
      plan_t p, q;
      // reset held with random inputs
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a_valid = 1'($urandom); b_valid = 1'($urandom);
         Ga = 1'($urandom); Gb = 1'($urandom);
         a_addr = 8'($urandom); b_addr = 8'($urandom);
         #1;
         check("rst_ready", {a_ready, b_ready}, 2'b11);
         check("rst_req", {Ra, Rb}, 2'b00);
         check("rst_bus", {s_sel, s_we, s_addr, s_wdata}, 0);
         check("rst_results", {a_err, b_err, a_rdata, b_rdata}, 0);
      end
      @(negedge clk);
      a_valid = 0; b_valid = 0; Ga = 0; Gb = 0;
      rst = 1;
      @(negedge clk);
      check("post_rst_ready", {a_ready, b_ready, Ra, Rb, s_sel}, 5'b11000);

      // write A, ack in second ISSUE cycle
      p = '{1'b1, 8'h3C, 8'hA5, 1, 8'h77};
      run_single(0, p, 0);
      // read B, data 5A
      p = '{1'b0, 8'h10, 8'h00, 2, 8'h5A};
      run_single(1, p, 1);
      // timeout on A: never acked
      p = '{1'b0, 8'h42, 8'h11, 255, 8'hFF};
      run_single(0, p, 0);
      // ack on the very last ISSUE cycle
      p = '{1'b0, 8'h43, 8'h12, TIMEOUT - 1, 8'hC3};
      run_single(1, p, 0);
      // contention: simultaneous grants, A first, Ga dropped mid-ISSUE
      p = '{1'b1, 8'h20, 8'h99, 3, 8'h00};
      q = '{1'b0, 8'h30, 8'h00, 0, 8'hE1};
      run_pair(p, q, 0);

      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 2))
            0: run_single(0, rand_plan(), 1'($urandom));
            1: run_single(1, rand_plan(), 1'($urandom));
            default: run_pair(rand_plan(), rand_plan(), 1'($urandom));
         endcase
      end

      // reset mid-ISSUE with B also pending: no done pulse afterwards
      p = '{1'b1, 8'h55, 8'h66, 255, 8'h00};
      q = '{1'b0, 8'h77, 8'h00, 0, 8'h88};
      bus_q.push_back(p); slv_q.push_back(p);
      drive_offer(0, p);
      drive_offer(1, q);
      end_offer();
      @(negedge clk);
      pulse_grant(1, 0, 0);
      repeat (3) @(negedge clk);
      check("issue_before_reset", s_sel, 1);
      #2;
      rst = 0;
      #1;
      check("rst_async_s_sel", s_sel, 0);
      check("rst_async_ready", {a_ready, b_ready, Ra, Rb}, 4'b1100);
      bus_q.delete(); slv_q.delete();
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (10) @(negedge clk);
      check("post_midreset_ready", {a_ready, b_ready, Ra, Rb}, 4'b1100);
      p = '{1'b0, 8'h01, 8'h02, 1, 8'h3E};
      run_single(0, p, 0);

      check("exp_a_drained", exp_a.size(), 0);
      check("exp_b_drained", exp_b.size(), 0);
      check("bus_q_drained", bus_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
